// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default datapath widths and the
// common-data-bus record broadcast to reservation stations and the ROB.
package ooo_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } cdb_bus_t;

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found when
// scanning upward from ptr, wrapping from N-1 back to 0.
module rr_priority_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin : scan
    int          idx;
    logic [PW-1:0] sel;
    logic        found;
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    grant = '0;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      sel = PW'(idx);
      if (!found && request[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Common-data-bus scheduler: one holding slot per functional unit, one
// round-robin broadcast per cycle, squash on flush, contention statistics.
module cdb_scheduler #(
  parameter int N     = 4,
  parameter int XLEN  = ooo_pkg::XLEN,
  parameter int TAG_W = ooo_pkg::TAG_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*TAG_W-1:0]   req_tag,
  input  logic [N*XLEN-1:0]    req_value,
  output logic [N-1:0]         req_ready,
  input  logic                 flush,
  output logic                 cdb_valid,
  output logic [TAG_W-1:0]     cdb_tag,
  output logic [XLEN-1:0]      cdb_value,
  output logic [N-1:0]         cdb_grant,
  output logic [15:0]          conflict_count
);

  localparam int PW = $clog2(N);

  logic [N-1:0]     hv;
  logic [TAG_W-1:0] htag [N];
  logic [XLEN-1:0]  hval [N];
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gidx;
  logic [N-1:0]     arb_grant;
  logic [N-1:0]     capture;

  rr_priority_arbiter #(.N(N)) u_arb (
    .request (hv),
    .ptr     (rr_ptr),
    .grant   (arb_grant)
  );

  // A granted slot reports ready so the FU can refill it on the draining edge.
  assign cdb_grant = flush ? '0 : arb_grant;
  assign cdb_valid = |cdb_grant;
  assign req_ready = flush ? '0 : (~hv | cdb_grant);
  assign capture   = req_valid & req_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) gidx = PW'(i);
    end
  end

  assign cdb_tag   = cdb_valid ? htag[gidx] : '0;
  assign cdb_value = cdb_valid ? hval[gidx] : '0;

  // NOTE: slot payloads are reset along with their valid bits so nothing
  // stale from before reset can ever reach the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hv <= '0;
      for (int i = 0; i < N; i++) begin
        htag[i] <= '0;
        hval[i] <= '0;
      end
    end else if (flush) begin
      hv <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every slot update based on the
      // pre-edge state, independent of statement order.
      for (int i = 0; i < N; i++) begin
        if (capture[i]) begin
          hv[i]   <= 1'b1;
          htag[i] <= req_tag[i*TAG_W +: TAG_W];
          hval[i] <= req_value[i*XLEN +: XLEN];
        end else if (cdb_grant[i]) begin
          hv[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (cdb_valid) begin
      rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_count <= '0;
    end else if (!flush && ($countones(hv) >= 2) &&
                 (conflict_count != ooo_pkg::CONFLICT_MAX)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed scenarios plus randomized traffic for cdb_scheduler, checked every
// cycle against a slot-level behavioural model kept in this bench.
module tb_cdb_scheduler;
  import ooo_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         req_valid;
  logic [N*TAG_W-1:0]   req_tag;
  logic [N*XLEN-1:0]    req_value;
  logic [N-1:0]         req_ready;
  logic                 flush;
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [XLEN-1:0]      cdb_value;
  logic [N-1:0]         cdb_grant;
  logic [15:0]          conflict_count;

  int total = 0;
  int bad   = 0;

  // Model: what each FU slot holds, where the fairness search starts, and
  // how many contended cycles have been seen.
  bit               m_hv  [N];
  logic [TAG_W-1:0] m_tag [N];
  logic [XLEN-1:0]  m_val [N];
  bit               m_acc [N];
  int               m_ptr;
  int               m_cnt;

  cdb_scheduler #(.N(N), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .req_value      (req_value),
    .req_ready      (req_ready),
    .flush          (flush),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .cdb_grant      (cdb_grant),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i]  = 1'b0;
      m_tag[i] = '0;
      m_val[i] = '0;
      m_acc[i] = 1'b0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // Oldest-fairness rule: first occupied slot at or after the pointer, wrapping.
  function automatic int exp_gidx();
    if (flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (m_hv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_outputs(input int g);
    cdb_bus_t     eb;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    eg       = '0;
    eb.valid = (g >= 0);
    eb.tag   = '0;
    eb.value = '0;
    if (g >= 0) begin
      eg[g]    = 1'b1;
      eb.tag   = m_tag[g];
      eb.value = m_val[g];
    end
    for (int i = 0; i < N; i++) er[i] = !flush && (!m_hv[i] || g == i);
    check("cdb_valid", 32'(cdb_valid), 32'(eb.valid));
    check("cdb_tag", 32'(cdb_tag), 32'(eb.tag));
    check("cdb_value", cdb_value, eb.value);
    check("cdb_grant", 32'(cdb_grant), 32'(eg));
    check("req_ready", 32'(req_ready), 32'(er));
    check("conflict_count", 32'(conflict_count), 32'(m_cnt));
  endtask

  task automatic model_update(input int g);
    int pop;
    pop = 0;
    for (int i = 0; i < N; i++) pop += int'(m_hv[i]);
    if (!flush && pop >= 2 && m_cnt < 65535) m_cnt++;
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 1'b0;
      if (flush) begin
        m_hv[i] = 1'b0;
      end else if (req_valid[i] && (!m_hv[i] || g == i)) begin
        m_hv[i]  = 1'b1;
        m_tag[i] = req_tag[i*TAG_W +: TAG_W];
        m_val[i] = req_value[i*XLEN +: XLEN];
        m_acc[i] = 1'b1;
      end else if (g == i) begin
        m_hv[i] = 1'b0;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % N;
  endtask

  // One clock: check settled outputs against the model, then advance both.
  task automatic tick();
    int g;
    #2;
    g = exp_gidx();
    check_outputs(g);
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t,
                        input logic [XLEN-1:0] d);
    req_valid[i]                = v;
    req_tag[i*TAG_W +: TAG_W]   = t;
    req_value[i*XLEN +: XLEN]   = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_tag   = '0;
    req_value = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    check_outputs(-1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    do_reset();

    // Single FU: FU2 tag 7 broadcast one cycle after capture.
    set_fu(2, 1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    set_fu(2, 1'b0, '0, '0);
    #2;
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_tag", 32'(cdb_tag), 32'd7);
    check("single_value", cdb_value, 32'hDEADBEEF);
    check("single_grant", 32'(cdb_grant), 32'b0100);
    tick();

    // Wrap: pointer at 3 with slots 0 and 3 occupied.
    set_fu(0, 1'b1, 5'd1, 32'h0000_1111);
    set_fu(3, 1'b1, 5'd3, 32'h0000_3333);
    tick();
    clear_inputs();
    #2;
    check("wrap_grant_a", 32'(cdb_grant), 32'b1000);
    tick();
    #2;
    check("wrap_grant_b", 32'(cdb_grant), 32'b0001);
    tick();
    // Pointer now 1: FU1 must beat FU0.
    set_fu(0, 1'b1, 5'd4, 32'h0000_4444);
    set_fu(1, 1'b1, 5'd5, 32'h0000_5555);
    tick();
    clear_inputs();
    #2;
    check("ptr_after_wrap", 32'(cdb_grant), 32'b0010);
    tick();
    tick();

    // All contend from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, TAG_W'(10 + i), XLEN'(32'hA000 + i));
    tick();
    clear_inputs();
    for (int k = 0; k < N; k++) begin
      #2;
      check("contend_grant", 32'(cdb_grant), 32'(1 << k));
      tick();
    end
    #2;
    check("contend_count", 32'(conflict_count), 32'd3);

    // Back-to-back: FU1 streams continuously.
    for (int k = 0; k < 6; k++) begin
      set_fu(1, 1'b1, TAG_W'(20 + k), XLEN'(32'hB000 + k));
      if (k > 0) begin
        #2;
        check("b2b_ready", 32'(req_ready[1]), 32'd1);
        check("b2b_valid", 32'(cdb_valid), 32'd1);
        check("b2b_tag", 32'(cdb_tag), 32'(20 + k - 1));
      end
      tick();
    end
    clear_inputs();
    tick();

    // Flush with slots 0..2 occupied; pointer (2) must survive.
    for (int i = 0; i < 3; i++) set_fu(i, 1'b1, TAG_W'(i + 1), XLEN'(32'hC000 + i));
    tick();
    clear_inputs();
    flush = 1'b1;
    #2;
    check("flush_valid", 32'(cdb_valid), 32'd0);
    check("flush_ready", 32'(req_ready), 32'd0);
    check("flush_grant", 32'(cdb_grant), 32'd0);
    tick();
    flush = 1'b0;
    #2;
    check("post_flush_valid", 32'(cdb_valid), 32'd0);
    check("post_flush_ready", 32'(req_ready), 32'b1111);
    set_fu(1, 1'b1, 5'd9, 32'h0000_9999);
    set_fu(3, 1'b1, 5'd11, 32'h0000_BBBB);
    tick();
    clear_inputs();
    #2;
    check("flush_ptr_kept", 32'(cdb_grant), 32'b1000);
    tick();
    tick();

    // Reset mid-run with every slot full and five contended cycles.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_fu(i, 1'b1, TAG_W'(k * 4 + i), XLEN'($urandom));
      tick();
    end
    #2;
    check("pre_reset_count", 32'(conflict_count), 32'd5);
    check("pre_reset_valid", 32'(cdb_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_valid", 32'(cdb_valid), 32'd0);
    check("async_grant", 32'(cdb_grant), 32'd0);
    check("async_tag", 32'(cdb_tag), 32'd0);
    check("async_value", cdb_value, 32'd0);
    check("async_ready", 32'(req_ready), 32'b1111);
    check("async_count", 32'(conflict_count), 32'd0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Randomized traffic; a blocked FU keeps its data until accepted.
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(15) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !m_acc[i])) begin
          if ($urandom_range(2) != 0) set_fu(i, 1'b1, TAG_W'($urandom), XLEN'($urandom));
          else set_fu(i, 1'b0, '0, '0);
        end
      end
      tick();
    end
    clear_inputs();
    repeat (N + 1) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
